// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller slice.
package regfile_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned X0_IDX = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  function automatic req_e other_req(input req_e r);
    return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back request bundle: ALU result, load return and load issue handshakes.
interface regfile_wb_ctrl_if
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int ADDR = ADDR_W
);

  logic            alu_valid;
  logic [ADDR-1:0] alu_wa;
  logic [DATA-1:0] alu_wd;
  logic            alu_ready;

  logic            mem_valid;
  logic [ADDR-1:0] mem_wa;
  logic [DATA-1:0] mem_wd;
  logic            mem_ready;

  logic            iss_valid;
  logic [ADDR-1:0] iss_rd;
  logic            iss_ready;

  modport master (
    output alu_valid, alu_wa, alu_wd,
    input  alu_ready,
    output mem_valid, mem_wa, mem_wd,
    input  mem_ready,
    output iss_valid, iss_rd,
    input  iss_ready
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    output alu_ready,
    input  mem_valid, mem_wa, mem_wd,
    output mem_ready,
    input  iss_valid, iss_rd,
    output iss_ready
  );

endinterface

// File: rtl/regfile_wb_ctrl_scoreboard.sv
// Per-register pending-load scoreboard: WAW issue gate and load-pending hazard.
module regfile_scoreboard
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR = ADDR_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            set_valid_i,
  input  logic [ADDR-1:0] set_rd_i,
  input  logic            clr_i,
  input  logic [ADDR-1:0] clr_rd_i,
  input  logic [ADDR-1:0] rs1_i,
  input  logic [ADDR-1:0] rs2_i,
  output logic            iss_ready_o,
  output logic            hazard_o
);

  localparam int unsigned NREG = 2 ** ADDR;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            set_en;

  always_comb begin
    iss_ready_o = ~pending_q[set_rd_i];
    set_en      = set_valid_i & iss_ready_o & (set_rd_i != ADDR'(X0_IDX));
  end

  // Clear first so a set to the same register in the same cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_i)
      pending_d[clr_rd_i] = 1'b0;
    if (set_en)
      pending_d[set_rd_i] = 1'b1;
    pending_d[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end

  always_comb begin
    hazard_o = ((rs1_i != ADDR'(X0_IDX)) & pending_q[rs1_i])
             | ((rs2_i != ADDR'(X0_IDX)) & pending_q[rs2_i]);
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter (ALU vs load return) with registered write
// and decode-stage hazard generation.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int ADDR = ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  regfile_wb_ctrl_if.slave  wb,
  input  logic [ADDR-1:0]   rs1_i,
  input  logic [ADDR-1:0]   rs2_i,
  output logic              hazard_o,
  output logic              rf_we_o,
  output logic [ADDR-1:0]   rf_wa_o,
  output logic [DATA-1:0]   rf_wd_o
);

  req_e            prio_q;
  logic            contest;
  logic            alu_gnt;
  logic            mem_gnt;
  logic [ADDR-1:0] gnt_wa;
  logic [DATA-1:0] gnt_wd;

  logic            rf_we_q, rf_we_d;
  logic [ADDR-1:0] rf_wa_q, rf_wa_d;
  logic [DATA-1:0] rf_wd_q, rf_wd_d;

  logic            sb_hazard;
  logic            fwd_hazard;

  always_comb begin
    contest = wb.alu_valid & wb.mem_valid;
    alu_gnt = wb.alu_valid & (~wb.mem_valid | (prio_q == REQ_ALU));
    mem_gnt = wb.mem_valid & (~wb.alu_valid | (prio_q == REQ_MEM));
    gnt_wa  = mem_gnt ? wb.mem_wa : wb.alu_wa;
    gnt_wd  = mem_gnt ? wb.mem_wd : wb.alu_wd;
  end

  assign wb.alu_ready = alu_gnt;
  assign wb.mem_ready = mem_gnt;

  // Address/data hold when idle; only the enable drops.
  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (alu_gnt | mem_gnt) begin
      rf_we_d = (gnt_wa != ADDR'(X0_IDX));
      rf_wa_d = gnt_wa;
      rf_wd_d = gnt_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q  <= REQ_MEM;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      if (contest)
        prio_q <= other_req(prio_q);
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  regfile_scoreboard #(
    .ADDR (ADDR)
  ) u_scoreboard (
    .clk         (clk),
    .rstn        (rstn),
    .set_valid_i (wb.iss_valid),
    .set_rd_i    (wb.iss_rd),
    .clr_i       (mem_gnt),
    .clr_rd_i    (wb.mem_wa),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .iss_ready_o (wb.iss_ready),
    .hazard_o    (sb_hazard)
  );

  always_comb begin
    fwd_hazard = rf_we_q &
                 (((rs1_i != ADDR'(X0_IDX)) & (rs1_i == rf_wa_q)) |
                  ((rs2_i != ADDR'(X0_IDX)) & (rs2_i == rf_wa_q)));
  end

  assign hazard_o = sb_hazard | fwd_hazard;
  assign rf_we_o  = rf_we_q;
  assign rf_wa_o  = rf_wa_q;
  assign rf_wd_o  = rf_wd_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: arbitration, write register, scoreboard, reset.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rstn;
  logic [4:0]  rs1, rs2;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_ctrl_if #(.DATA(32), .ADDR(5)) wb ();

  regfile_wb_ctrl #(
    .DATA (32),
    .ADDR (5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wb       (wb),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .hazard_o (hazard),
    .rf_we_o  (rf_we),
    .rf_wa_o  (rf_wa),
    .rf_wd_o  (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0; wb.alu_wa = '0; wb.alu_wd = '0;
    wb.mem_valid = 1'b0; wb.mem_wa = '0; wb.mem_wd = '0;
    wb.iss_valid = 1'b0; wb.iss_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  logic [4:0]  a_wa [2] = '{5'd10, 5'd11};
  logic [31:0] a_wd [2] = '{32'hA000_0000, 32'hA111_1111};
  logic [4:0]  m_wa [2] = '{5'd12, 5'd13};
  logic [31:0] m_wd [2] = '{32'hB000_0000, 32'hB111_1111};
  logic        exp_mem [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0]  exp_wa  [4] = '{5'd12, 5'd10, 5'd13, 5'd11};
  logic [31:0] exp_wd  [4] = '{32'hB000_0000, 32'hA000_0000, 32'hB111_1111, 32'hA111_1111};
  int ai, mi;

  initial begin
    idle();
    rstn = 1'b0;
    #2;
    check("rst_we", rf_we, 0);
    check("rst_wa", rf_wa, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_hazard", hazard, 0);
    check("rst_iss_ready", wb.iss_ready, 1);
    #10 rstn = 1'b1;

    // Uncontested ALU write, forward hazard for one cycle
    next_cycle();
    wb.alu_valid = 1'b1; wb.alu_wa = 5'd5; wb.alu_wd = 32'hDEADBEEF; rs1 = 5'd5;
    settle();
    check("alu_ready", wb.alu_ready, 1);
    check("alu_mem_ready", wb.mem_ready, 0);
    check("alu_hazard_pre", hazard, 0);
    next_cycle();
    wb.alu_valid = 1'b0;
    settle();
    check("alu_we", rf_we, 1);
    check("alu_wa", rf_wa, 5);
    check("alu_wd", rf_wd, 32'hDEADBEEF);
    check("alu_hazard_fwd", hazard, 1);
    next_cycle();
    settle();
    check("alu_we_drop", rf_we, 0);
    check("alu_hazard_drop", hazard, 0);
    check("alu_wd_hold", rf_wd, 32'hDEADBEEF);

    // Contested requests, both requesters hold until accepted
    ai = 0; mi = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      idle();
      if (ai < 2) begin
        wb.alu_valid = 1'b1; wb.alu_wa = a_wa[ai]; wb.alu_wd = a_wd[ai];
      end
      if (mi < 2) begin
        wb.mem_valid = 1'b1; wb.mem_wa = m_wa[mi]; wb.mem_wd = m_wd[mi];
      end
      settle();
      check($sformatf("arb_mem_ready_%0d", k), wb.mem_ready, exp_mem[k]);
      check($sformatf("arb_alu_ready_%0d", k), wb.alu_ready, !exp_mem[k]);
      if (k > 0) begin
        check($sformatf("arb_wa_%0d", k - 1), rf_wa, exp_wa[k - 1]);
        check($sformatf("arb_wd_%0d", k - 1), rf_wd, exp_wd[k - 1]);
      end
      if (wb.alu_ready) ai++;
      if (wb.mem_ready) mi++;
    end
    next_cycle();
    idle();
    settle();
    check("arb_wa_3", rf_wa, exp_wa[3]);
    check("arb_wd_3", rf_wd, exp_wd[3]);
    check("arb_we_3", rf_we, 1);
    check("arb_alu_count", ai, 2);
    check("arb_mem_count", mi, 2);

    // Load to x7: pending, WAW block, return, hazard through rf_we cycle
    next_cycle();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd7; rs2 = 5'd7;
    settle();
    check("ld_iss_ready", wb.iss_ready, 1);
    check("ld_hazard_pre", hazard, 0);
    next_cycle();
    wb.iss_valid = 1'b0;
    settle();
    check("ld_iss_blocked", wb.iss_ready, 0);
    check("ld_hazard_pend", hazard, 1);
    next_cycle();
    wb.mem_valid = 1'b1; wb.mem_wa = 5'd7; wb.mem_wd = 32'h1234; wb.iss_valid = 1'b1;
    settle();
    check("ld_ret_ready", wb.mem_ready, 1);
    check("ld_ret_waw", wb.iss_ready, 0);
    check("ld_ret_hazard", hazard, 1);
    next_cycle();
    wb.mem_valid = 1'b0; wb.iss_valid = 1'b0;
    settle();
    check("ld_we", rf_we, 1);
    check("ld_wa", rf_wa, 7);
    check("ld_wd", rf_wd, 32'h1234);
    check("ld_hazard_we", hazard, 1);
    check("ld_iss_free", wb.iss_ready, 1);
    next_cycle();
    settle();
    check("ld_hazard_done", hazard, 0);

    // x0 destination: consumed, no write, never pending
    next_cycle();
    idle();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd0;
    wb.alu_valid = 1'b1; wb.alu_wa = 5'd0; wb.alu_wd = 32'h0000FFFF;
    settle();
    check("x0_alu_ready", wb.alu_ready, 1);
    check("x0_iss_ready", wb.iss_ready, 1);
    next_cycle();
    wb.iss_valid = 1'b0; wb.alu_valid = 1'b0;
    settle();
    check("x0_we", rf_we, 0);
    check("x0_wd", rf_wd, 32'h0000FFFF);
    check("x0_hazard", hazard, 0);
    check("x0_iss_ready_after", wb.iss_ready, 1);

    // Same-cycle set of x3 and clear of x9
    next_cycle();
    idle();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd9;
    settle();
    check("sc_iss9", wb.iss_ready, 1);
    next_cycle();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd3;
    wb.mem_valid = 1'b1; wb.mem_wa = 5'd9; wb.mem_wd = 32'h99;
    settle();
    check("sc_iss3", wb.iss_ready, 1);
    check("sc_ret9", wb.mem_ready, 1);
    next_cycle();
    idle();
    rs1 = 5'd3; wb.iss_rd = 5'd9;
    settle();
    check("sc_pend9_clear", wb.iss_ready, 1);
    check("sc_pend3_hazard", hazard, 1);
    next_cycle();
    rs1 = 5'd9; wb.iss_rd = 5'd3;
    settle();
    check("sc_rs9_no_hazard", hazard, 0);
    check("sc_pend3_set", wb.iss_ready, 0);

    // Reset mid-traffic
    next_cycle();
    idle();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd4;
    wb.alu_valid = 1'b1; wb.alu_wa = 5'd6; wb.alu_wd = 32'h66;
    next_cycle();
    idle();
    rs1 = 5'd4; rs2 = 5'd6; wb.iss_rd = 5'd4;
    #1;
    check("mr_hazard_before", hazard, 1);
    check("mr_we_before", rf_we, 1);
    rstn = 1'b0;
    #1;
    check("mr_we", rf_we, 0);
    check("mr_wa", rf_wa, 0);
    check("mr_hazard", hazard, 0);
    check("mr_iss_ready", wb.iss_ready, 1);
    settle();
    rstn = 1'b1;
    next_cycle();
    settle();
    check("mr_hazard_after", hazard, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the integer register file. It arbitrates the single register-file write port between the ALU write-back path and the cache/memory load-return path, and registers the winning write toward the register file. It also keeps a per-register pending-load scoreboard that drives the decode-stage hazard stall. It sits between the execute/memory stages and the register file's WE/WA/WD port.

## Interface
Parameters:
- DATA, 32, data width of a register
- ADDR, 5, register address width; 2**ADDR registers, x0 hard-wired zero

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result ready for write-back
- alu_wa  in  ADDR  ALU destination register
- alu_wd  in  DATA  ALU result
- alu_ready  out  1  ALU write accepted this cycle
- mem_valid  in  1  load data returned from cache/memory
- mem_wa  in  ADDR  load destination register
- mem_wd  in  DATA  load data
- mem_ready  out  1  load write accepted this cycle
- iss_valid  in  1  load being issued; marks iss_rd pending
- iss_rd  in  ADDR  destination of issued load
- iss_ready  out  1  load issue permitted
- rs1, rs2  in  ADDR  decode-stage source registers
- hazard  out  1  decode must stall
- rf_we  out  1  register-file write enable
- rf_wa  out  ADDR  register-file write address
- rf_wd  out  DATA  register-file write data

## Operation
- Handshake: a transfer occurs when valid && ready. The ready outputs are combinational from the valid inputs and the priority pointer only. There is no downstream backpressure.
- Arbitration:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the grant goes to the requester named by prio_ptr. The loser's ready is 0 and it must hold its valid, wa and wd.
  - prio_ptr toggles to the other requester only after a contested grant. Uncontested grants leave it unchanged.
- Output register: on each grant, rf_wa<=granted wa, rf_wd<=granted wd, rf_we<=(granted wa!=0).
  - No grant: rf_we<=0; rf_wa and rf_wd hold.
  - A write to x0 is consumed (ready=1) but produces no rf_we.
- Scoreboard: pending[2**ADDR-1:0].
  - Set: on iss_valid && iss_ready with iss_rd!=0, pending[iss_rd]<=1.
  - Clear: on a mem grant, pending[mem_wa]<=0.
  - pending[0] is always 0.
- iss_ready = !pending[iss_rd], evaluated from registered state. A second load to a register that is still pending is blocked (WAW), including in the cycle that register's load returns.
- A set and a clear of different registers in the same cycle both take effect.
- hazard=1 if any of the following holds for a source s in {rs1, rs2} with s!=0:
  - pending[s]=1, or
  - rf_we=1 && rf_wa==s (the write has not yet landed in the register file).
- ALU grants never touch the scoreboard.

## Timing
- Reset (asynchronous) values:
  - rf_we=0, rf_wa=0, rf_wd=0
  - pending=0
  - prio_ptr=MEM (memory wins the first contest)
  - Consequently hazard=0 and iss_ready=1.
- Latency:
  - Grant cycle N produces rf_we/rf_wa/rf_wd in cycle N+1.
  - The register file updates at the edge ending N+1, so a read returns the new value from cycle N+2.
  - hazard covers cycles N+1 (via rf_we) and any load-pending interval.
- Scoreboard update is visible on hazard and iss_ready in the cycle after the set or clear edge.
- Reset asserted mid-operation discards all pending state and any in-flight output write. Upstream stages are reset by the same rstn.

## Structure
- Shared package regfile_ctrl_pkg:
  - requester-ID enum (REQ_ALU, REQ_MEM)
  - DATA/ADDR defaults
  - the x0 index constant
- Sub-module regfile_scoreboard holds the pending vector, the set/clear logic, iss_ready, and the pending part of hazard.
- Arbitration, the output register, and the rf_we-forward hazard term stay in the top level.

## Test plan
- Reset then idle: rf_we=0, hazard=0, iss_ready=1, pending=0. Assert rstn low mid-traffic: the same values appear immediately.
- alu_valid only, alu_wa=5, alu_wd=0xDEADBEEF: alu_ready=1. Next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF. rs1=5 gives hazard=1 for that cycle only.
- Both valid on four consecutive cycles, requesters holding until accepted: grants go MEM, ALU, MEM, ALU. No request is lost, and each rf write matches its requester's wa/wd.
- Issue load rd=7: iss_ready=0 next cycle for iss_rd=7, and rs2=7 gives hazard=1. Return mem_wa=7, mem_wd=0x1234: hazard stays 1 through the rf_we cycle, then drops, and iss_ready returns to 1.
- Issue load rd=0 and ALU write to x0: no pending bit, no rf_we, hazard=0 for rs1=0.
- Same cycle: issue load rd=3 while load rd=9 returns. Result: pending[3]=1, pending[9]=0.
